sdram_arbiter: RTL and testbench

Slot-based arbiter that shares the single byte-wide SDRAM port between three requesters: the ROM/program downloader, the video fetch engine and the CPU memory path. It sits between those requesters and the `sdram` controller, clocked by F14M. It replaces the static download/VTL multiplexer and issues exactly one SDRAM access per slot. A CPU anti-starvation counter guarantees CPU progress under continuous video traffic.

---
 rtl/sdram_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Shares the byte-wide SDRAM port between the program downloader (dl), the
// video fetch engine (vid) and the CPU memory path (cpu). Each grant owns the
// port for one fixed-length slot of SLOT_LEN F14M cycles, then a single DONE
// cycle pulses the owner's ack. A saturating starvation counter lets a
// waiting CPU outrank continuous video traffic after STARVE_MAX video grants.
//
// Ports:
//   F14M, RESET_n                 clock and asynchronous active-low reset
//   dl_req/dl_addr/dl_din/dl_ack  downloader write channel
//   vid_req/vid_addr/vid_dout/vid_ack   video read channel
//   cpu_req/cpu_wr/cpu_addr/cpu_din/cpu_dout/cpu_ack/cpu_wait_n   CPU channel
//   sdram_addr/sdram_din/sdram_wr/sdram_rd/sdram_dout   SDRAM controller side
//   busy                          high whenever the arbiter is not in IDLE
module sdram_arbiter #(
    parameter int SLOT_LEN   = 2,
    parameter int ADDR_W     = 25,
    parameter int STARVE_MAX = 8
) (
    input  logic              F14M,
    input  logic              RESET_n,
    input  logic              dl_req,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_din,
    output logic              dl_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [7:0]        vid_dout,
    output logic              vid_ack,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ack,
    output logic              cpu_wait_n,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [7:0]        sdram_din,
    output logic              sdram_wr,
    output logic              sdram_rd,
    input  logic [7:0]        sdram_dout,
    output logic              busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_DL, OWN_VID, OWN_CPU} owner_t;

    state_t            state_reg;
    owner_t            owner_reg;
    owner_t            grant_next;
    logic [3:0]        slot_reg;
    logic [3:0]        starve_cnt_reg;
    logic [ADDR_W-1:0] sdram_addr_reg;
    logic [7:0]        sdram_din_reg;
    logic              sdram_wr_reg;
    logic              sdram_rd_reg;
    logic [7:0]        vid_dout_reg;
    logic [7:0]        cpu_dout_reg;
    logic              dl_ack_reg;
    logic              vid_ack_reg;
    logic              cpu_ack_reg;
    logic              cpu_starved;

    // A CPU that has watched STARVE_MAX video grants go by jumps ahead of video,
    // but never ahead of the downloader.
    assign cpu_starved = (starve_cnt_reg >= 4'(STARVE_MAX));

    always_comb begin
        grant_next = OWN_NONE;
        if (dl_req)
            grant_next = OWN_DL;
        else if (cpu_req && cpu_starved)
            grant_next = OWN_CPU;
        else if (vid_req)
            grant_next = OWN_VID;
        else if (cpu_req)
            grant_next = OWN_CPU;
    end

    always_ff @(posedge F14M or negedge RESET_n) begin
        if (!RESET_n) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= OWN_NONE;
            slot_reg       <= 4'd0;
            starve_cnt_reg <= 4'd0;
            sdram_addr_reg <= '0;
            sdram_din_reg  <= 8'd0;
            sdram_wr_reg   <= 1'b0;
            sdram_rd_reg   <= 1'b0;
            vid_dout_reg   <= 8'd0;
            cpu_dout_reg   <= 8'd0;
            dl_ack_reg     <= 1'b0;
            vid_ack_reg    <= 1'b0;
            cpu_ack_reg    <= 1'b0;
        end else begin
            // Acks are single-cycle: set on entry to DONE, cleared here on exit.
            dl_ack_reg  <= 1'b0;
            vid_ack_reg <= 1'b0;
            cpu_ack_reg <= 1'b0;

            // Starvation tracking only matters while the CPU is actually waiting.
            if (!cpu_req)
                starve_cnt_reg <= 4'd0;
            else if (state_reg == ST_IDLE && grant_next == OWN_CPU)
                starve_cnt_reg <= 4'd0;
            else if (state_reg == ST_IDLE && grant_next == OWN_VID && starve_cnt_reg != 4'hF)
                starve_cnt_reg <= starve_cnt_reg + 4'd1;

            case (state_reg)
                ST_IDLE: begin
                    if (grant_next != OWN_NONE) begin
                        owner_reg <= grant_next;
                        slot_reg  <= 4'd0;
                        state_reg <= ST_ACCESS;
                        case (grant_next)
                            OWN_DL: begin
                                sdram_addr_reg <= dl_addr;
                                sdram_din_reg  <= dl_din;
                                sdram_wr_reg   <= 1'b1;
                                sdram_rd_reg   <= 1'b0;
                            end
                            OWN_VID: begin
                                sdram_addr_reg <= vid_addr;
                                sdram_din_reg  <= 8'd0;
                                sdram_wr_reg   <= 1'b0;
                                sdram_rd_reg   <= 1'b1;
                            end
                            default: begin
                                sdram_addr_reg <= cpu_addr;
                                sdram_din_reg  <= cpu_din;
                                sdram_wr_reg   <= cpu_wr;
                                sdram_rd_reg   <= ~cpu_wr;
                            end
                        endcase
                    end
                end
                ST_ACCESS: begin
                    if (slot_reg == 4'(SLOT_LEN - 1)) begin
                        state_reg    <= ST_DONE;
                        sdram_wr_reg <= 1'b0;
                        sdram_rd_reg <= 1'b0;
                        // Capture on the last strobe cycle, when the controller's
                        // read data is guaranteed settled.
                        case (owner_reg)
                            OWN_DL:  dl_ack_reg <= 1'b1;
                            OWN_VID: begin
                                vid_ack_reg  <= 1'b1;
                                vid_dout_reg <= sdram_dout;
                            end
                            OWN_CPU: begin
                                cpu_ack_reg <= 1'b1;
                                if (sdram_rd_reg)
                                    cpu_dout_reg <= sdram_dout;
                            end
                            default: ;
                        endcase
                    end else begin
                        slot_reg <= slot_reg + 4'd1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    owner_reg <= OWN_NONE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign dl_ack     = dl_ack_reg;
    assign vid_ack    = vid_ack_reg;
    assign cpu_ack    = cpu_ack_reg;
    assign vid_dout   = vid_dout_reg;
    assign cpu_dout   = cpu_dout_reg;
    assign sdram_addr = sdram_addr_reg;
    assign sdram_din  = sdram_din_reg;
    assign sdram_wr   = sdram_wr_reg;
    assign sdram_rd   = sdram_rd_reg;
    assign busy       = (state_reg != ST_IDLE);

    // WAIT releases in the ack cycle itself; forced inactive while in reset.
    assign cpu_wait_n = ~(cpu_req & ~cpu_ack_reg) | ~RESET_n;

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

    localparam int SLOT_LEN   = 2;
    localparam int ADDR_W     = 25;
    localparam int STARVE_MAX = 8;

    logic              F14M;
    logic              RESET_n;
    logic              dl_req;
    logic [ADDR_W-1:0] dl_addr;
    logic [7:0]        dl_din;
    logic              dl_ack;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [7:0]        vid_dout;
    logic              vid_ack;
    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_din;
    logic [7:0]        cpu_dout;
    logic              cpu_ack;
    logic              cpu_wait_n;
    logic [ADDR_W-1:0] sdram_addr;
    logic [7:0]        sdram_din;
    logic              sdram_wr;
    logic              sdram_rd;
    logic [7:0]        sdram_dout;
    logic              busy;

    // SDRAM read model: address-derived byte, or a forced value.
    logic       ovr_en;
    logic [7:0] ovr_val;
    assign sdram_dout = ovr_en ? ovr_val : (sdram_addr[7:0] ^ 8'h3C);

    sdram_arbiter #(.SLOT_LEN(SLOT_LEN), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .F14M(F14M), .RESET_n(RESET_n),
        .dl_req(dl_req), .dl_addr(dl_addr), .dl_din(dl_din), .dl_ack(dl_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
        .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_wr(sdram_wr),
        .sdram_rd(sdram_rd), .sdram_dout(sdram_dout), .busy(busy)
    );

    initial F14M = 1'b0;
    always #5 F14M = ~F14M;

    typedef struct {
        logic [1:0]        owner;   // 1 dl, 2 vid, 3 cpu
        logic [ADDR_W-1:0] addr;
        logic [7:0]        din;
        logic              wr;
        logic [7:0]        dout;
    } exp_t;

    typedef struct {
        bit         dl;
        bit         vid;
        bit         cpu;
        bit         cpu_wr;
        logic [1:0] o0;
        logic [1:0] o1;
        logic [1:0] o2;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_ack_cyc = -1;
    bit   gap_en = 1'b0;
    bit   auto_drop = 1'b1;
    bit   mon_en = 1'b0;
    int   strobe_cnt = 0;
    int   n_dl = 0, n_vid = 0, n_cpu = 0;
    logic [7:0] last_vid = 8'd0;
    logic [7:0] last_cpu = 8'd0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end else begin
            $display("ok   %s = %0h (cycle %0d)", name, got, cyc);
        end
    endtask

    function automatic logic [7:0] model_rd(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] t;
        t = a;
        return ovr_en ? ovr_val : (t[7:0] ^ 8'h3C);
    endfunction

    function automatic void push(input logic [1:0] o);
        exp_t e;
        e.owner = o;
        case (o)
            2'd1: begin e.addr = dl_addr;  e.din = dl_din;  e.wr = 1'b1;   e.dout = 8'd0; end
            2'd2: begin e.addr = vid_addr; e.din = 8'd0;    e.wr = 1'b0;   e.dout = model_rd(vid_addr); end
            default: begin
                e.addr = cpu_addr; e.din = cpu_din; e.wr = cpu_wr;
                e.dout = cpu_wr ? 8'd0 : model_rd(cpu_addr);
            end
        endcase
        sb.push_back(e);
    endfunction

    // Scoreboard monitor: strobes checked against the head entry, acks pop it.
    always @(negedge F14M) begin
        if (!mon_en) begin
            strobe_cnt = 0;
        end else begin
            if (sdram_wr || sdram_rd) begin
                strobe_cnt++;
                if (sb.size() == 0) begin
                    check("strobe_unexpected", 32'(sdram_addr), 32'hFFFF_FFFF);
                end else begin
                    check("strobe_addr", 32'(sdram_addr), 32'(sb[0].addr));
                    check("strobe_wr", 32'(sdram_wr), 32'(sb[0].wr));
                    check("strobe_rd", 32'(sdram_rd), 32'(!sb[0].wr));
                    if (sb[0].wr) check("strobe_din", 32'(sdram_din), 32'(sb[0].din));
                end
            end
            if (dl_ack || vid_ack || cpu_ack) begin
                logic [1:0] code;
                exp_t e;
                code = dl_ack ? 2'd1 : (vid_ack ? 2'd2 : 2'd3);
                check("ack_onehot", 32'(dl_ack) + 32'(vid_ack) + 32'(cpu_ack), 32'd1);
                if (sb.size() == 0) begin
                    check("ack_unexpected", 32'(code), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ack_owner", 32'(code), 32'(e.owner));
                    check("strobe_count", 32'(strobe_cnt), 32'(SLOT_LEN));
                    if (e.owner == 2'd2) last_vid = e.dout;
                    if (e.owner == 2'd3 && !e.wr) last_cpu = e.dout;
                    check("vid_dout", 32'(vid_dout), 32'(last_vid));
                    check("cpu_dout", 32'(cpu_dout), 32'(last_cpu));
                end
                strobe_cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge F14M);
        #1;
        cyc++;
        if (dl_ack || vid_ack || cpu_ack) begin
            if (gap_en && last_ack_cyc >= 0)
                check("ack_gap", 32'(cyc - last_ack_cyc), 32'(SLOT_LEN + 2));
            last_ack_cyc = cyc;
        end
        if (dl_ack)  begin n_dl++;  if (auto_drop) dl_req = 1'b0;  end
        if (vid_ack) begin n_vid++; if (auto_drop) vid_req = 1'b0; end
        if (cpu_ack) begin n_cpu++; if (auto_drop) cpu_req = 1'b0; end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_dl_ack"}, 32'(dl_ack), 32'd0);
        check({tag, "_vid_ack"}, 32'(vid_ack), 32'd0);
        check({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
        check({tag, "_sdram_wr"}, 32'(sdram_wr), 32'd0);
        check({tag, "_sdram_rd"}, 32'(sdram_rd), 32'd0);
        check({tag, "_sdram_addr"}, 32'(sdram_addr), 32'd0);
        check({tag, "_sdram_din"}, 32'(sdram_din), 32'd0);
        check({tag, "_vid_dout"}, 32'(vid_dout), 32'd0);
        check({tag, "_cpu_dout"}, 32'(cpu_dout), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_wait_n"}, 32'(cpu_wait_n), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          dl    vid   cpu   wr    expected grant order
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 2'd0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 2'd0, 2'd0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd2, 2'd0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 2'd3, 2'd0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 2'd3, 2'd0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 2'd2, 2'd3};

        RESET_n = 1'b0;
        dl_req = 1'b0; dl_addr = '0; dl_din = 8'd0;
        vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_din = 8'd0;
        ovr_en = 1'b0; ovr_val = 8'd0;

        // Reset idle
        repeat (3) step();
        RESET_n = 1'b1;
        step();
        check_idle_outputs("reset");
        mon_en = 1'b1;

        // CPU read latency, cycle by cycle
        step();
        auto_drop = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 25'h01234;
        ovr_en = 1'b1; ovr_val = 8'hA5;
        push(2'd3);
        #1;
        check("lat_c0_wait_n", 32'(cpu_wait_n), 32'd0);
        check("lat_c0_rd", 32'(sdram_rd), 32'd0);
        check("lat_c0_busy", 32'(busy), 32'd0);
        step();
        check("lat_c1_rd", 32'(sdram_rd), 32'd1);
        check("lat_c1_ack", 32'(cpu_ack), 32'd0);
        check("lat_c1_wait_n", 32'(cpu_wait_n), 32'd0);
        check("lat_c1_busy", 32'(busy), 32'd1);
        step();
        check("lat_c2_rd", 32'(sdram_rd), 32'd1);
        check("lat_c2_ack", 32'(cpu_ack), 32'd0);
        step();
        check("lat_c3_ack", 32'(cpu_ack), 32'd1);
        check("lat_c3_rd", 32'(sdram_rd), 32'd0);
        check("lat_c3_wait_n", 32'(cpu_wait_n), 32'd1);
        check("lat_c3_dout", 32'(cpu_dout), 32'hA5);
        cpu_req = 1'b0; auto_drop = 1'b1; ovr_en = 1'b0;
        step();
        check("lat_c4_ack", 32'(cpu_ack), 32'd0);
        check("lat_c4_busy", 32'(busy), 32'd0);

        // Table-driven request patterns
        for (int v = 0; v < 8; v++) begin
            step();
            gap_en = 1'b1; last_ack_cyc = -1;
            dl_addr = ADDR_W'($urandom); dl_din = 8'($urandom);
            vid_addr = ADDR_W'($urandom);
            cpu_addr = ADDR_W'($urandom); cpu_din = 8'($urandom); cpu_wr = vecs[v].cpu_wr;
            dl_req = vecs[v].dl; vid_req = vecs[v].vid; cpu_req = vecs[v].cpu;
            if (vecs[v].o0 != 2'd0) push(vecs[v].o0);
            if (vecs[v].o1 != 2'd0) push(vecs[v].o1);
            if (vecs[v].o2 != 2'd0) push(vecs[v].o2);
            repeat (16) step();
            gap_en = 1'b0;
            check("vec_drained", 32'(sb.size()), 32'd0);
            check("vec_busy", 32'(busy), 32'd0);
        end

        // Starvation: video and CPU held high continuously
        step();
        auto_drop = 1'b0;
        n_vid = 0; n_cpu = 0;
        vid_addr = 25'h0_0100; cpu_addr = 25'h0_0200; cpu_wr = 1'b0;
        vid_req = 1'b1; cpu_req = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < STARVE_MAX; k++) push(2'd2);
            push(2'd3);
        end
        for (int i = 0; i < 200; i++) begin
            step();
            if (n_cpu == 2) begin
                vid_req = 1'b0; cpu_req = 1'b0;
                break;
            end
        end
        auto_drop = 1'b1;
        repeat (6) step();
        check("starve_vid_acks", 32'(n_vid), 32'(2 * STARVE_MAX));
        check("starve_cpu_acks", 32'(n_cpu), 32'd2);
        check("starve_drained", 32'(sb.size()), 32'd0);

        // Reset in the middle of a CPU write
        step();
        n_cpu = 0;
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 25'h1AB_CDEF; cpu_din = 8'h5C;
        push(2'd3);
        step();
        check("rst_pre_wr", 32'(sdram_wr), 32'd1);
        mon_en = 1'b0;
        #1;
        RESET_n = 1'b0;
        #1;
        check("rst_wr_drop", 32'(sdram_wr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wait_n", 32'(cpu_wait_n), 32'd1);
        check("rst_addr", 32'(sdram_addr), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_no_ack", 32'(cpu_ack), 32'd0);
        end
        RESET_n = 1'b1;
        sb.delete();
        last_vid = 8'd0; last_cpu = 8'd0;
        push(2'd3);
        mon_en = 1'b1;
        repeat (8) step();
        check("rst_cpu_served", 32'(n_cpu), 32'd1);
        check("rst_drained", 32'(sb.size()), 32'd0);

        // Video request withdrawn right after its grant
        step();
        n_vid = 0;
        vid_addr = 25'h0_4321;
        vid_req = 1'b1;
        push(2'd2);
        step();
        vid_req = 1'b0;
        repeat (8) step();
        check("wd_vid_acks", 32'(n_vid), 32'd1);
        check("wd_busy", 32'(busy), 32'd0);
        check("wd_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
